any1_memseq: RTL and testbench
==============================

// Module: any1_memseq
// PURPOSE
//  Load/store memory sequencer directly downstream of address generation. Drives step to the agen,
//  latches the returned ea, and runs bus cycles on a Wishbone-style 64-bit data bus.
//  Splits unaligned accesses that cross an 8-byte boundary; sign/zero-extends load data.
//  Iterates vector/strided ops over elements 0..vl-1.
// PARAMETERS
//  TO_CYCLES  255  bus timeout in clocks; used only with ANY1_MEMSEQ_TIMEOUT_EN
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-high
//  req_valid  in   1   operation request
//  req_ready  out  1   sequencer idle, request accepted when valid&ready
//  req_store  in   1   1=store 0=load
//  req_size   in   2   0=byte 1=wyde 2=tetra 3=octa
//  req_signed in   1   sign-extend load result
//  req_vec    in   1   vector/strided op; iterate over elements
//  req_vl     in   6   vector length (req_vec only)
//  req_data   in   64  store data, right-justified; held stable by the issuer during the op
//  step       out  6   element index to agen
//  ea         in   32  effective address from agen, valid 1 clk after step changes
//  wb_cyc_o   out  1   bus cycle
//  wb_stb_o   out  1   strobe
//  wb_we_o    out  1   write enable
//  wb_sel_o   out  8   byte lanes
//  wb_adr_o   out  32  word address, adr[2:0]=0
//  wb_dat_o   out  64  write data, lane-aligned
//  wb_ack_i   in   1   ack
//  wb_err_i   in   1   bus error
//  wb_dat_i   in   64  read data
//  res_valid  out  1   one-clk pulse per completed element
//  res_data   out  64  extended load data (0 for stores)
//  res_elem   out  6   element index of res_data
//  done       out  1   one-clk pulse at op end
//  fault      out  1   set with done when the op aborted; held until next accept
// BEHAVIOUR
//  Reset: all outputs 0, except req_ready=1; state IDLE.
//  FSM states: IDLE -> AWAIT -> BUS1 -> [BUS2] -> NEXT -> AWAIT | FIN -> IDLE.
//  IDLE: on valid&ready, latch request, step<=0, fault<=0, go AWAIT.
//    req_vec & req_vl==0: go FIN directly, no bus cycle.
//  AWAIT: 1 clk for agen latency; latch ea into ea_r.
//    Compute bytes=1<<size, off=ea_r[2:0], split=(off+bytes>8).
//  BUS1: cyc=stb=1, adr={ea_r[31:3],3'b0}, sel=(mask(size)<<off)[7:0].
//    dat_o=req_data<<(8*off). Hold all signals until ack or err.
//  BUS2 (split only): adr+8, sel=mask(size)>>(8-off), dat_o=req_data>>(8*(8-off)).
//    cyc held high between BUS1 and BUS2; stb dropped 1 clk.
//  Load data = {dat2,dat1}>>(8*off), truncated to size, then extended per req_signed.
//  NEXT: pulse res_valid, res_elem=step, drop cyc/stb.
//    If !req_vec or step==vl-1 -> FIN; else step<=step+1 -> AWAIT.
//  FIN: pulse done, req_ready<=1 next clk. Latency: scalar aligned op = 3 clk + ack wait.
//  wb_err_i in BUS1/BUS2: drop cyc/stb, fault<=1, no res_valid for that element, go FIN.
//  ack and err in the same clk: err wins.
//  step wraps never: vl<=63 enforced by 6-bit width.
//  rst mid-op: cyc/stb drop at next edge, partial store not retried.
//  req_valid ignored while busy (req_ready=0).
// CONFIGURATION
//  ANY1_MEMSEQ_TIMEOUT_EN defined: counter clears on stb rise and counts while stb&!ack&!err.
//    Reaching TO_CYCLES acts as wb_err_i (fault, FIN).
//  ANY1_MEMSEQ_TIMEOUT_EN undefined: counter absent; sequencer waits for ack/err indefinitely.
// STRUCTURE
//  any1_pkg: memsz_t enum (BYTE,WYDE,TETRA,OCTA), memseq_state_t enum, function sel_mask(memsz_t)->8b.
//  Sub-module any1_memseq_align (combinational): off,size,signed,dat1,dat2,st_data -> sel1,sel2,dout1,dout2,ldata.
// TESTING
//  Aligned octa load ea=0x1000, dat_i=0x8877665544332211 -> sel=FF, adr=0x1000, res_data=0x8877665544332211.
//  Signed byte load ea=0x1003, dat_i byte3=0x80 -> sel=08, res_data=0xFFFFFFFFFFFFFF80; unsigned -> 0x80.
//  Tetra store ea=0x1006, data=0xAABBCCDD -> BUS1 adr=0x1000 sel=C0; BUS2 adr=0x1008 sel=03, one res_valid.
//  Vector load vl=4 -> step 0,1,2,3 issued, 4 res_valid with res_elem 0..3, one done; vl=0 -> done, no cyc.
//  err on element 2 of vl=4 -> res_valid for elems 0,1 only, done with fault=1, cyc low next clk.
//  With TIMEOUT_EN, TO_CYCLES=8, no ack -> fault+done 8 clk after stb; rst mid-BUS1 -> cyc=0, req_ready=1.

Source files
------------

// File: rtl/any1_memseq_pkg.sv
// any1_memseq_pkg: shared types and helpers for the load/store memory sequencer.
//   memsz_t        : access size (byte, wyde, tetra, octa)
//   memseq_state_t : sequencer FSM states
//   sel_mask()     : right-justified byte-lane mask for a size
//   sz_bytes()     : number of bytes in an access of a size
package any1_memseq_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_WYDE  = 2'd1,
        SZ_TETRA = 2'd2,
        SZ_OCTA  = 2'd3
    } memsz_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AWAIT,
        ST_BUS1,
        ST_BUS2,
        ST_NEXT,
        ST_FIN
    } memseq_state_t;

    function automatic logic [7:0] sel_mask(input memsz_t sz);
        case (sz)
            SZ_BYTE:  return 8'h01;
            SZ_WYDE:  return 8'h03;
            SZ_TETRA: return 8'h0F;
            default:  return 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] sz_bytes(input memsz_t sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/any1_memseq_align.sv
// any1_memseq_align: combinational lane alignment for one element access.
// Ports:
//   i_off      byte offset of the element inside its 8-byte word
//   i_size     access size
//   i_signed   sign-extend load result
//   i_dat1     read data of the first bus word
//   i_dat2     read data of the second bus word (0 when not split)
//   i_st_data  right-justified store data
//   o_split    access crosses into the next 8-byte word
//   o_sel1/2   byte lanes for first/second bus word
//   o_dout1/2  lane-aligned write data for first/second bus word
//   o_ldata    right-justified, extended load data
module any1_memseq_align
    import any1_memseq_pkg::*;
(
    input  logic [2:0]  i_off,
    input  memsz_t      i_size,
    input  logic        i_signed,
    input  logic [63:0] i_dat1,
    input  logic [63:0] i_dat2,
    input  logic [63:0] i_st_data,
    output logic        o_split,
    output logic [7:0]  o_sel1,
    output logic [7:0]  o_sel2,
    output logic [63:0] o_dout1,
    output logic [63:0] o_dout2,
    output logic [63:0] o_ldata
);

    logic [5:0]   w_sh;
    logic [15:0]  w_sel_wide;
    logic [127:0] w_st_wide;
    logic [63:0]  w_ld_raw;

    assign w_sh = {i_off, 3'b000};

    // Shifting into a double-width word yields both halves of a split access
    // at once: the upper half is exactly what spills into the next word.
    assign w_sel_wide = {8'h00, sel_mask(i_size)} << i_off;
    assign w_st_wide  = {64'h0, i_st_data} << w_sh;
    assign o_sel1     = w_sel_wide[7:0];
    assign o_sel2     = w_sel_wide[15:8];
    assign o_dout1    = w_st_wide[63:0];
    assign o_dout2    = w_st_wide[127:64];

    assign o_split  = ({1'b0, i_off} + sz_bytes(i_size)) > 4'd8;
    assign w_ld_raw = 64'({i_dat2, i_dat1} >> w_sh);

    always_comb begin
        o_ldata = w_ld_raw;
        case (i_size)
            SZ_BYTE:  o_ldata = {{56{i_signed & w_ld_raw[7]}},  w_ld_raw[7:0]};
            SZ_WYDE:  o_ldata = {{48{i_signed & w_ld_raw[15]}}, w_ld_raw[15:0]};
            SZ_TETRA: o_ldata = {{32{i_signed & w_ld_raw[31]}}, w_ld_raw[31:0]};
            default:  o_ldata = w_ld_raw;
        endcase
    end

endmodule

// File: rtl/any1_memseq.sv
// any1_memseq: load/store memory sequencer behind address generation.
// Drives the element index to the agen, takes the effective address one clock
// later, and runs Wishbone-style cycles on a 64-bit bus. Accesses crossing an
// 8-byte boundary become two bus cycles with cyc held high between them.
// Vector ops iterate elements 0..vl-1; any bus error aborts the op with fault.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    operation request (valid/ready handshake)
//   step / ea                element index out, effective address back
//   wb_*                     bus master interface
//   res_valid/data/elem      per-element completion
//   done / fault             end of op, fault held until next accept
// Configuration macro: ANY1_MEMSEQ_TIMEOUT_EN enables a bus timeout of
// TO_CYCLES clocks that behaves like wb_err_i.
module any1_memseq
    import any1_memseq_pkg::*;
#(
    parameter int TO_CYCLES = 255
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic        req_vec,
    input  logic [5:0]  req_vl,
    input  logic [63:0] req_data,
    output logic [5:0]  step,
    input  logic [31:0] ea,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [7:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [63:0] wb_dat_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [63:0] wb_dat_i,
    output logic        res_valid,
    output logic [63:0] res_data,
    output logic [5:0]  res_elem,
    output logic        done,
    output logic        fault
);

    memseq_state_t r_state;
    logic          r_store;
    memsz_t        r_size;
    logic          r_signed;
    logic          r_vec;
    logic [5:0]    r_vl;
    logic [2:0]    r_off;
    logic          r_split;
    logic [63:0]   r_dat1;

    logic [2:0]    w_off;
    logic [63:0]   w_dat1;
    logic [63:0]   w_dat2;
    logic          w_split;
    logic [7:0]    w_sel1;
    logic [7:0]    w_sel2;
    logic [63:0]   w_dout1;
    logic [63:0]   w_dout2;
    logic [63:0]   w_ldata;
    logic          w_to;
    logic          w_bus_err;

    // In AWAIT the fresh ea is used directly so the bus signals can be
    // registered on the way into BUS1; later states use the latched offset.
    assign w_off  = (r_state == ST_AWAIT) ? ea[2:0] : r_off;
    assign w_dat1 = (r_state == ST_BUS2) ? r_dat1   : wb_dat_i;
    assign w_dat2 = (r_state == ST_BUS2) ? wb_dat_i : 64'd0;

    any1_memseq_align u_align (
        .i_off     (w_off),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .i_dat1    (w_dat1),
        .i_dat2    (w_dat2),
        .i_st_data (req_data),
        .o_split   (w_split),
        .o_sel1    (w_sel1),
        .o_sel2    (w_sel2),
        .o_dout1   (w_dout1),
        .o_dout2   (w_dout2),
        .o_ldata   (w_ldata)
    );

`ifdef ANY1_MEMSEQ_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    // Counts clocks of the current strobe; clearing while stb is low makes
    // every strobe rise start from zero.
    always_ff @(posedge clk) begin
        if (rst || !wb_stb_o)
            r_to_cnt <= '0;
        else if (!wb_ack_i && !wb_err_i)
            r_to_cnt <= r_to_cnt + 16'd1;
    end

    assign w_to = wb_stb_o && !wb_ack_i && ({16'd0, r_to_cnt} == 32'(TO_CYCLES - 1));
`else
    logic w_unused_to;
    assign w_unused_to = (TO_CYCLES != 0);
    assign w_to        = 1'b0;
`endif

    assign w_bus_err = wb_err_i | w_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_store   <= 1'b0;
            r_size    <= SZ_BYTE;
            r_signed  <= 1'b0;
            r_vec     <= 1'b0;
            r_vl      <= '0;
            r_off     <= '0;
            r_split   <= 1'b0;
            r_dat1    <= '0;
            req_ready <= 1'b1;
            step      <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_elem  <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_store   <= req_store;
                        r_size    <= memsz_t'(req_size);
                        r_signed  <= req_signed;
                        r_vec     <= req_vec;
                        r_vl      <= req_vl;
                        step      <= '0;
                        fault     <= 1'b0;
                        req_ready <= 1'b0;
                        if (req_vec && req_vl == 6'd0) begin
                            done    <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_state <= ST_AWAIT;
                        end
                    end
                end
                ST_AWAIT: begin
                    r_off    <= ea[2:0];
                    r_split  <= w_split;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_we_o  <= r_store;
                    wb_adr_o <= {ea[31:3], 3'b000};
                    wb_sel_o <= w_sel1;
                    wb_dat_o <= r_store ? w_dout1 : 64'd0;
                    r_state  <= ST_BUS1;
                end
                ST_BUS1: begin
                    if (w_bus_err) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        fault    <= 1'b1;
                        done     <= 1'b1;
                        r_state  <= ST_FIN;
                    end else if (wb_ack_i) begin
                        if (r_split) begin
                            // cyc stays up; stb drops for one clock between halves
                            r_dat1   <= wb_dat_i;
                            wb_stb_o <= 1'b0;
                            wb_adr_o <= wb_adr_o + 32'd8;
                            wb_sel_o <= w_sel2;
                            wb_dat_o <= r_store ? w_dout2 : 64'd0;
                            r_state  <= ST_BUS2;
                        end else begin
                            wb_cyc_o  <= 1'b0;
                            wb_stb_o  <= 1'b0;
                            wb_we_o   <= 1'b0;
                            res_valid <= 1'b1;
                            res_data  <= r_store ? 64'd0 : w_ldata;
                            res_elem  <= step;
                            r_state   <= ST_NEXT;
                        end
                    end
                end
                ST_BUS2: begin
                    if (!wb_stb_o) begin
                        wb_stb_o <= 1'b1;
                    end else if (w_bus_err) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        fault    <= 1'b1;
                        done     <= 1'b1;
                        r_state  <= ST_FIN;
                    end else if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        res_valid <= 1'b1;
                        res_data  <= r_store ? 64'd0 : w_ldata;
                        res_elem  <= step;
                        r_state   <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (!r_vec || step == r_vl - 6'd1) begin
                        done    <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        step    <= step + 6'd1;
                        r_state <= ST_AWAIT;
                    end
                end
                ST_FIN: begin
                    req_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_any1_memseq.sv
// Bench for any1_memseq: byte-level reference memory model, randomized ops,
// scoreboard queues for bus cycles, element results and op completion.
module tb_any1_memseq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0, req_vec = 1'b0;
    logic [5:0]  req_vl = 6'd0;
    logic [63:0] req_data = 64'd0;
    logic [5:0]  step;
    logic [31:0] ea;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [63:0] wb_dat_o;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic [63:0] wb_dat_i = 64'd0;
    logic        res_valid, done, fault;
    logic [63:0] res_data;
    logic [5:0]  res_elem;

    always #5 clk = ~clk;

    // agen stand-in: address follows step within the same clock
    logic [31:0] ag_base = 32'd0, ag_stride = 32'd0;
    assign ea = ag_base + ag_stride * {26'd0, step};

    any1_memseq #(.TO_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
        .req_vec(req_vec), .req_vl(req_vl), .req_data(req_data), .step(step), .ea(ea),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_dat_i(wb_dat_i), .res_valid(res_valid), .res_data(res_data), .res_elem(res_elem),
        .done(done), .fault(fault)
    );

    typedef struct {
        logic [31:0] adr;
        logic [7:0]  sel;
        logic        we;
        logic [63:0] dat;
        bit          split1;
    } bus_t;
    typedef struct {
        logic [63:0] data;
        logic [5:0]  elem;
    } res_t;

    bus_t        exp_bus[$];
    res_t        exp_res[$];
    bit          exp_done[$];
    logic [7:0]  ref_mem[int unsigned];
    logic [7:0]  sl_mem[int unsigned];
    logic [31:0] obs_adr[$];
    logic [7:0]  obs_sel[$];
    logic [63:0] last_res = 64'd0;
    int n_chk = 0, n_pass = 0;
    int err_at = -1, sl_txn = 0, done_cnt = 0;
    bit sl_hang = 1'b0;

    task automatic chk_b(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_b(act === exp, nm, act, exp);
    endtask

    function automatic logic [7:0] dflt(input int unsigned a);
        return 8'(a ^ (a >> 8) ^ 32'h5A);
    endfunction
    function automatic logic [7:0] rd_ref(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction
    function automatic logic [7:0] rd_sl(input int unsigned a);
        return sl_mem.exists(a) ? sl_mem[a] : dflt(a);
    endfunction

    // Reference: walk elements and the bytes each touches; every 8-byte word
    // touched is one bus cycle. An erroring cycle ends the op.
    task automatic model_op(input bit st, input int sz, input bit sg, input bit vec, input int vl,
                            input logic [63:0] data, input logic [31:0] base, input logic [31:0] stride,
                            input int err_idx);
        int nel, n, txn, nw;
        bit ab;
        logic [31:0] ea_e, a;
        logic [63:0] val;
        bus_t b;
        nel = vec ? vl : 1;
        n = 1 << sz;
        txn = 0;
        ab = 0;
        for (int e = 0; e < nel && !ab; e++) begin
            ea_e = base + stride * e;
            nw = ((ea_e & 32'h7) + n > 8) ? 2 : 1;
            for (int w = 0; w < nw && !ab; w++) begin
                b.adr = (ea_e & ~32'h7) + 32'(8 * w);
                b.sel = 8'h00;
                b.we = st;
                b.dat = 64'd0;
                b.split1 = (nw == 2 && w == 0);
                for (int i = 0; i < n; i++) begin
                    a = ea_e + i;
                    if ((a & ~32'h7) == b.adr) begin
                        b.sel[a & 7] = 1'b1;
                        b.dat[8 * (a & 7) +: 8] = data[8 * i +: 8];
                    end
                end
                exp_bus.push_back(b);
                if (txn == err_idx) ab = 1;
                else begin
                    if (st)
                        for (int i = 0; i < n; i++) begin
                            a = ea_e + i;
                            if ((a & ~32'h7) == b.adr) ref_mem[a] = data[8 * i +: 8];
                        end
                    txn++;
                end
            end
            if (!ab) begin
                val = 64'd0;
                if (!st) begin
                    for (int i = 0; i < n; i++) val[8 * i +: 8] = rd_ref(ea_e + i);
                    if (sg && val[8 * n - 1])
                        for (int i = n; i < 8; i++) val[8 * i +: 8] = 8'hFF;
                end
                exp_res.push_back('{val, 6'(e)});
            end
        end
        exp_done.push_back(ab);
    endtask

    task automatic issue(input bit st, input int sz, input bit sg, input bit vec, input int vl,
                         input logic [63:0] data, input logic [31:0] base, input logic [31:0] stride,
                         input int err_idx);
        int t = 0;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        if (!req_ready) chk_b(0, "ready_timeout", 64'(req_ready), 64'd1);
        ag_base = base; ag_stride = stride; err_at = err_idx; sl_txn = 0;
        obs_adr.delete(); obs_sel.delete();
        model_op(st, sz, sg, vec, vl, data, base, stride, err_idx);
        req_store = st; req_size = 2'(sz); req_signed = sg; req_vec = vec;
        req_vl = 6'(vl); req_data = data; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_op(input bit st, input int sz, input bit sg, input bit vec, input int vl,
                         input logic [63:0] data, input logic [31:0] base, input logic [31:0] stride,
                         input int err_idx);
        int t = 0, d0;
        d0 = done_cnt;
        issue(st, sz, sg, vec, vl, data, base, stride, err_idx);
        while (done_cnt == d0 && t < 3000) begin @(negedge clk); t++; end
        if (done_cnt == d0) chk_b(0, "done_timeout", 64'(t), 64'd3000);
        chk("bus_cycles_left", 64'(exp_bus.size()), 64'd0);
    endtask

    // Bus slave: random ack delay, byte memory, compares every cycle it serves.
    initial begin
        int dly = 0, wcnt = 0;
        bit chk_low = 0, gap_chk = 0;
        bus_t b;
        logic [63:0] lm, rd;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (chk_low) begin chk("cyc_low_after_err", 64'(wb_cyc_o), 64'd0); chk_low = 0; end
            if (gap_chk) begin
                chk("split_gap_stb", 64'(wb_stb_o), 64'd0);
                chk("split_gap_cyc", 64'(wb_cyc_o), 64'd1);
                gap_chk = 0;
            end
            if (!rst && wb_cyc_o && wb_stb_o && !sl_hang) begin
                if (wcnt < dly) wcnt++;
                else begin
                    wcnt = 0;
                    dly = $urandom_range(0, 2);
                    obs_adr.push_back(wb_adr_o);
                    obs_sel.push_back(wb_sel_o);
                    if (exp_bus.size() == 0) begin
                        chk_b(0, "bus_unexpected_cycle", 64'(wb_adr_o), 64'd0);
                        wb_ack_i = 1'b1;
                    end else begin
                        b = exp_bus.pop_front();
                        chk("bus_adr", 64'(wb_adr_o), 64'(b.adr));
                        chk("bus_sel", 64'(wb_sel_o), 64'(b.sel));
                        chk("bus_we", 64'(wb_we_o), 64'(b.we));
                        lm = 64'd0;
                        for (int j = 0; j < 8; j++) if (b.sel[j]) lm[8 * j +: 8] = 8'hFF;
                        if (b.we) chk("bus_wdat", wb_dat_o & lm, b.dat);
                        if (sl_txn == err_at) begin
                            wb_err_i = 1'b1;
                            wb_ack_i = 1'($urandom_range(0, 1));
                            chk_low = 1;
                        end else begin
                            wb_ack_i = 1'b1;
                            gap_chk = b.split1;
                            if (wb_we_o) begin
                                for (int j = 0; j < 8; j++)
                                    if (wb_sel_o[j]) sl_mem[wb_adr_o + j] = wb_dat_o[8 * j +: 8];
                            end else begin
                                for (int j = 0; j < 8; j++) rd[8 * j +: 8] = rd_sl(wb_adr_o + j);
                                wb_dat_i = rd;
                            end
                        end
                        sl_txn++;
                    end
                end
            end
        end
    end

    // Result/completion monitor
    initial begin
        res_t r;
        bit f;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (res_valid) begin
                    if (exp_res.size() == 0) chk_b(0, "res_unexpected", 64'(res_elem), 64'd0);
                    else begin
                        r = exp_res.pop_front();
                        chk("res_data", res_data, r.data);
                        chk("res_elem", 64'(res_elem), 64'(r.elem));
                    end
                    last_res = res_data;
                end
                if (done) begin
                    done_cnt++;
                    chk("res_count_at_done", 64'(exp_res.size()), 64'd0);
                    if (exp_done.size() == 0) chk_b(0, "done_unexpected", 64'(fault), 64'd0);
                    else begin
                        f = exp_done.pop_front();
                        chk("fault", 64'(fault), 64'(f));
                    end
                end
            end
        end
    end

    initial begin
        int t, cnt;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_cyc", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
        chk("rst_pulses", 64'({res_valid, done, fault}), 64'd0);
        chk("rst_step", 64'(step), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            ref_mem[32'h1000 + i] = 8'(8'h11 * (i + 1));
            sl_mem[32'h1000 + i]  = 8'(8'h11 * (i + 1));
        end
        do_op(0, 3, 0, 0, 0, 64'd0, 32'h1000, 32'd0, -1);
        chk("octa_adr", 64'(obs_adr[0]), 64'h1000);
        chk("octa_sel", 64'(obs_sel[0]), 64'hFF);
        chk("octa_data", last_res, 64'h8877665544332211);

        ref_mem[32'h1003] = 8'h80;
        sl_mem[32'h1003]  = 8'h80;
        do_op(0, 0, 1, 0, 0, 64'd0, 32'h1003, 32'd0, -1);
        chk("sbyte_sel", 64'(obs_sel[0]), 64'h08);
        chk("sbyte_data", last_res, 64'hFFFFFFFFFFFFFF80);
        do_op(0, 0, 0, 0, 0, 64'd0, 32'h1003, 32'd0, -1);
        chk("ubyte_data", last_res, 64'h80);

        do_op(1, 2, 0, 0, 0, 64'h00000000AABBCCDD, 32'h1006, 32'd0, -1);
        chk("tstore_ncyc", 64'(obs_adr.size()), 64'd2);
        chk("tstore_adr1", 64'(obs_adr[0]), 64'h1000);
        chk("tstore_sel1", 64'(obs_sel[0]), 64'hC0);
        chk("tstore_adr2", 64'(obs_adr[1]), 64'h1008);
        chk("tstore_sel2", 64'(obs_sel[1]), 64'h03);
        chk("tstore_mem", 64'({rd_sl(32'h1009), rd_sl(32'h1008), rd_sl(32'h1007), rd_sl(32'h1006)}),
            64'hAABBCCDD);

        do_op(0, 3, 0, 1, 4, 64'd0, 32'h1200, 32'd8, -1);
        chk("vec4_ncyc", 64'(obs_adr.size()), 64'd4);
        do_op(0, 3, 0, 1, 0, 64'd0, 32'h1200, 32'd8, -1);
        chk("vl0_ncyc", 64'(obs_adr.size()), 64'd0);
        do_op(0, 2, 0, 1, 4, 64'd0, 32'h1300, 32'd8, 2);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] stv;
            int sz;
            sz = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0: stv = 32'(1 << sz);
                1: stv = 32'($urandom_range(0, 20));
                default: stv = 32'd3;
            endcase
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 6), {$urandom, $urandom},
                  32'h2000 + 32'($urandom_range(0, 255)), stv,
                  ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1);
        end

`ifdef ANY1_MEMSEQ_TIMEOUT_EN
        sl_hang = 1'b1;
        issue(0, 3, 0, 0, 0, 64'd0, 32'h1000, 32'd0, 0);
        cnt = 0; t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            if (wb_stb_o) cnt++;
            t++;
        end
        chk("timeout_clks", 64'(cnt), 64'd8);
        exp_bus.delete();
        sl_hang = 1'b0;
        @(negedge clk);
`endif

        sl_hang = 1'b1;
        issue(1, 3, 0, 0, 0, 64'h0123456789ABCDEF, 32'h1400, 32'd0, -1);
        t = 0;
        while (!wb_stb_o && t < 20) begin @(negedge clk); t++; end
        chk("rstmid_in_bus", 64'(wb_stb_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rstmid_ready", 64'(req_ready), 64'd1);
        exp_bus.delete(); exp_res.delete(); exp_done.delete();
        sl_hang = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
